dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the byte address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the data word width.
REQ-003 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high (clock clk).
REQ-004 SHALL have core request ports: c_req_valid in 1; c_req_ready out 1; c_req_we in 1 (1=write); c_req_addr in ADDR_W; c_req_wdata in DATA_W.
REQ-005 SHALL have core response ports: c_rsp_valid out 1 (one-cycle pulse); c_rsp_rdata out DATA_W.
REQ-006 SHALL have host (loader/debug) ports h_req_valid, h_req_ready, h_req_we, h_req_addr, h_req_wdata, h_rsp_valid, h_rsp_rdata, with the same directions, widths and meanings as the core ports.
REQ-007 SHALL have memory ports: mem_en out 1; mem_we out 1; mem_addr out ADDR_W; mem_wdata out DATA_W; mem_rdata in DATA_W (valid one cycle after mem_en).
REQ-008 SHALL have status ports: busy out 1 (state != IDLE); owner out 1 (0=core, 1=host, the last granted requester).

Function
REQ-009 SHALL implement the FSM IDLE -> ACCESS -> RESP -> IDLE with no other states; ACCESS and RESP each last exactly one cycle.
REQ-010 SHALL assert *_req_ready only in IDLE and only for the granted requester; a request SHALL be accepted when valid and ready are both high.
REQ-011 SHALL, on acceptance, register we/addr/wdata and the owner, and SHALL go to ACCESS on the next cycle.
REQ-012 SHALL drive mem_en=1 and the registered mem_we/mem_addr/mem_wdata in ACCESS only, and SHALL drive mem_en=0 and mem_we=0 in all other cycles.
REQ-013 SHALL, in RESP, pulse the owner's rsp_valid for exactly one cycle with rsp_rdata=mem_rdata, and SHALL never pulse the other requester's rsp_valid.
REQ-014 SHALL register the last read data per requester, so that rsp_rdata holds its value until that requester's next RESP.
REQ-015 SHALL give write requests a response pulse (acknowledge) whose rsp_rdata value is don't-care.
REQ-016 SHALL have a fixed 2-cycle latency from acceptance (cycle N) to rsp_valid (cycle N+2), with at most one transaction every 3 cycles.
REQ-017 SHALL keep a request line that is not granted stalled, with no loss of the request; requesters SHALL hold valid and payload stable until accepted.
REQ-018 SHALL provide no response backpressure; requesters SHALL accept rsp_valid unconditionally.
REQ-019 SHALL resolve simultaneous valid in IDLE per REQ-024 and REQ-025.

Reset
REQ-020 SHALL, while rst is high, force state=IDLE, busy=0, owner=0, both req_ready=0, both rsp_valid=0, mem_en=0, mem_we=0, and zero all registered address, data and rdata values.
REQ-021 SHALL, when rst is asserted mid-transaction, abandon the transaction with no response pulse; a write already issued in ACCESS stands.
REQ-022 SHALL not assert req_ready in the first cycle after rst deasserts.

Configuration
REQ-023 SHALL select the arbitration policy with the macro DMEM_ARB_ROUND_ROBIN_EN.
REQ-024 SHALL, with DMEM_ARB_ROUND_ROBIN_EN defined and both requesters valid, grant the requester that is not owner; it SHALL grant a single valid requester directly.
REQ-025 SHALL, with DMEM_ARB_ROUND_ROBIN_EN undefined, use fixed priority: the core SHALL always win and the host SHALL be granted only when c_req_valid=0.

Structure
REQ-026 SHALL place in shared package hotate_pkg: the state enum type arb_state_t {IDLE, ACCESS, RESP}, the constants OWNER_CORE=1'b0 and OWNER_HOST=1'b1, and a request struct {we, addr, wdata}.
REQ-027 SHALL factor the grant decision into one combinational sub-module, arb_grant (inputs: both valids and owner; output: grant), and SHALL keep the FSM in dmem_arbiter.

Verification
REQ-028 SHALL cover: core write addr 0x10 data 0xDEADBEEF, then core read 0x10 -> mem_en/mem_we=1 one cycle, c_rsp_valid at N+2, read returns 0xDEADBEEF.
REQ-029 SHALL cover: core and host valid together, both round-robin and fixed priority -> RR alternates core, host, core...; fixed priority grants the core 4 times before the host.
REQ-030 SHALL cover: host read 0x20 while the core is idle -> h_rsp_valid only, c_rsp_valid stays 0, and c_rsp_rdata is unchanged.
REQ-031 SHALL cover: rst asserted during ACCESS of a core read -> no c_rsp_valid, all outputs at reset values the next cycle, busy=0.
REQ-032 SHALL cover: back-to-back core reads of 0x0, 0x4, 0x8 -> acceptances exactly 3 cycles apart, and data in order.

Source files
------------

// File: rtl/hotate_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Package field widths are the upper bound for the arbiter's ADDR_W/DATA_W.
package hotate_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;

  localparam logic OWNER_CORE = 1'b0;
  localparam logic OWNER_HOST = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } arb_req_t;

endpackage

// File: rtl/arb_grant.sv
// Grant decision between core and host requesters (0=core, 1=host).
// DMEM_ARB_ROUND_ROBIN_EN selects round-robin; default is fixed core priority.
module arb_grant
  import hotate_pkg::*;
(
  input  logic c_valid,
  input  logic h_valid,
  input  logic owner,
  output logic grant
);

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  always_comb begin
    if (c_valid && h_valid) grant = ~owner;
    else if (c_valid)       grant = OWNER_CORE;
    else if (h_valid)       grant = OWNER_HOST;
    else                    grant = owner;
  end
`else
  logic unused_owner;
  assign unused_owner = owner;

  always_comb begin
    grant = (!c_valid && h_valid) ? OWNER_HOST : OWNER_CORE;
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: IDLE -> ACCESS -> RESP, one access per 3 cycles.
// Arbitration policy chosen by DMEM_ARB_ROUND_ROBIN_EN (see arb_grant).
module dmem_arbiter
  import hotate_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req_valid,
  output logic              c_req_ready,
  input  logic              c_req_we,
  input  logic [ADDR_W-1:0] c_req_addr,
  input  logic [DATA_W-1:0] c_req_wdata,
  output logic              c_rsp_valid,
  output logic [DATA_W-1:0] c_rsp_rdata,
  input  logic              h_req_valid,
  output logic              h_req_ready,
  input  logic              h_req_we,
  input  logic [ADDR_W-1:0] h_req_addr,
  input  logic [DATA_W-1:0] h_req_wdata,
  output logic              h_rsp_valid,
  output logic [DATA_W-1:0] h_rsp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  arb_state_t        state, state_nxt;
  arb_req_t          req_q, req_sel;
  logic              owner_q;
  logic              ready_en;
  logic              grant;
  logic              idle_open;
  logic              accept;
  logic [DATA_W-1:0] c_rdata_q, h_rdata_q;

  arb_grant u_grant (
    .c_valid (c_req_valid),
    .h_valid (h_req_valid),
    .owner   (owner_q),
    .grant   (grant)
  );

  // ready_en keeps the first post-reset cycle closed to requests
  assign idle_open = (state == IDLE) && ready_en && !rst;
  assign accept    = idle_open && (grant ? h_req_valid : c_req_valid);

  always_comb begin
    req_sel.we    = grant ? h_req_we : c_req_we;
    req_sel.addr  = ARB_ADDR_W'(grant ? h_req_addr : c_req_addr);
    req_sel.wdata = ARB_DATA_W'(grant ? h_req_wdata : c_req_wdata);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_en  <= 1'b0;
      owner_q   <= OWNER_CORE;
      req_q     <= '0;
      c_rdata_q <= '0;
      h_rdata_q <= '0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        owner_q <= grant;
        req_q   <= req_sel;
      end
      // only reads refresh the held data; write acks leave it alone
      if (state == RESP && !req_q.we) begin
        if (owner_q == OWNER_HOST) h_rdata_q <= mem_rdata;
        else                       c_rdata_q <= mem_rdata;
      end
    end
  end

  always_comb begin
    c_req_ready = idle_open && (grant == OWNER_CORE);
    h_req_ready = idle_open && (grant == OWNER_HOST);
    mem_en      = !rst && (state == ACCESS);
    mem_we      = mem_en && req_q.we;
    mem_addr    = rst ? '0 : ADDR_W'(req_q.addr);
    mem_wdata   = rst ? '0 : DATA_W'(req_q.wdata);
    c_rsp_valid = !rst && (state == RESP) && (owner_q == OWNER_CORE);
    h_rsp_valid = !rst && (state == RESP) && (owner_q == OWNER_HOST);
    c_rsp_rdata = rst ? '0 : (c_rsp_valid ? mem_rdata : c_rdata_q);
    h_rsp_rdata = rst ? '0 : (h_rsp_valid ? mem_rdata : h_rdata_q);
    busy        = !rst && (state != IDLE);
    owner       = rst ? OWNER_CORE : owner_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural memory behind it.
// Expectations follow DMEM_ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        c_req_valid = 1'b0, c_req_we = 1'b0;
  logic [31:0] c_req_addr = '0, c_req_wdata = '0;
  logic        c_req_ready, c_rsp_valid;
  logic [31:0] c_rsp_rdata;
  logic        h_req_valid = 1'b0, h_req_we = 1'b0;
  logic [31:0] h_req_addr = '0, h_req_wdata = '0;
  logic        h_req_ready, h_rsp_valid;
  logic [31:0] h_rsp_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        busy, owner;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] mem [0:63];

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_we(c_req_we),
    .c_req_addr(c_req_addr), .c_req_wdata(c_req_wdata),
    .c_rsp_valid(c_rsp_valid), .c_rsp_rdata(c_rsp_rdata),
    .h_req_valid(h_req_valid), .h_req_ready(h_req_ready), .h_req_we(h_req_we),
    .h_req_addr(h_req_addr), .h_req_wdata(h_req_wdata),
    .h_rsp_valid(h_rsp_valid), .h_rsp_rdata(h_rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xact(input bit host, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rd,
                      input logic [31:0] other_hold, input string tag,
                      output int acc_cyc);
    int n = 0;
    if (host) begin
      h_req_valid = 1'b1; h_req_we = we; h_req_addr = addr; h_req_wdata = wdata;
    end else begin
      c_req_valid = 1'b1; c_req_we = we; c_req_addr = addr; c_req_wdata = wdata;
    end
    #1;
    while (!(host ? h_req_ready : c_req_ready) && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    chk({tag, "_accept"}, 32'(n < 20), 32'd1);
    acc_cyc = cyc;
    @(posedge clk); #1;
    c_req_valid = 1'b0;
    h_req_valid = 1'b0;
    #1;
    chk({tag, "_mem_en"}, 32'(mem_en), 32'd1);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'(we));
    chk({tag, "_mem_addr"}, mem_addr, addr);
    if (we) chk({tag, "_mem_wdata"}, mem_wdata, wdata);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_early_rsp"}, 32'({c_rsp_valid, h_rsp_valid}), 32'd0);
    @(posedge clk); #2;
    chk({tag, "_latency"}, 32'(cyc - acc_cyc), 32'd2);
    chk({tag, "_rsp_own"}, 32'(host ? h_rsp_valid : c_rsp_valid), 32'd1);
    chk({tag, "_rsp_other"}, 32'(host ? c_rsp_valid : h_rsp_valid), 32'd0);
    chk({tag, "_owner"}, 32'(owner), 32'(host));
    chk({tag, "_other_rdata"}, host ? c_rsp_rdata : h_rsp_rdata, other_hold);
    chk({tag, "_mem_en_resp"}, 32'(mem_en), 32'd0);
    if (!we) chk({tag, "_rdata"}, host ? h_rsp_rdata : c_rsp_rdata, exp_rd);
    @(posedge clk); #2;
    chk({tag, "_rsp_done"}, 32'({c_rsp_valid, h_rsp_valid}), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    if (!we) chk({tag, "_rdata_hold"}, host ? h_rsp_rdata : c_rsp_rdata, exp_rd);
  endtask

  initial begin
    int acc, prev;
    logic [31:0] c_hold, h_hold;
    bit exp_g [4];
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    exp_g = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'h1111_1111;
    mem[1] = 32'h2222_2222;
    mem[2] = 32'h3333_3333;
    mem[8] = 32'hCAFE_F00D;
    c_hold = 32'h0;
    h_hold = 32'h0;

    // reset state
    @(posedge clk); @(posedge clk); #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_ready", 32'({c_req_ready, h_req_ready}), 32'd0);
    chk("rst_rsp", 32'({c_rsp_valid, h_rsp_valid}), 32'd0);
    chk("rst_mem", 32'({mem_en, mem_we}), 32'd0);
    chk("rst_c_rdata", c_rsp_rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);

    // first cycle out of reset stays closed even with a request pending
    @(posedge clk); #1;
    rst = 1'b0;
    c_req_valid = 1'b1; c_req_we = 1'b1; c_req_addr = 32'h10; c_req_wdata = 32'hDEAD_BEEF;
    #1;
    chk("post_rst_ready", 32'(c_req_ready), 32'd0);
    @(posedge clk); #2;

    xact(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, h_hold, "c_wr10", acc);
    c_hold = 32'hDEAD_BEEF;
    xact(1'b0, 1'b0, 32'h10, 32'h0, c_hold, h_hold, "c_rd10", acc);

    h_hold = 32'hCAFE_F00D;
    xact(1'b1, 1'b0, 32'h20, 32'h0, h_hold, c_hold, "h_rd20", acc);

    // back-to-back core reads
    xact(1'b0, 1'b0, 32'h0, 32'h0, 32'h1111_1111, h_hold, "b2b_0", prev);
    xact(1'b0, 1'b0, 32'h4, 32'h0, 32'h2222_2222, h_hold, "b2b_4", acc);
    chk("b2b_gap_a", 32'(acc - prev), 32'd3);
    prev = acc;
    xact(1'b0, 1'b0, 32'h8, 32'h0, 32'h3333_3333, h_hold, "b2b_8", acc);
    chk("b2b_gap_b", 32'(acc - prev), 32'd3);

    // both requesters valid together
    c_req_valid = 1'b1; c_req_we = 1'b0; c_req_addr = 32'h0;
    h_req_valid = 1'b1; h_req_we = 1'b0; h_req_addr = 32'h20;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("arb%0d_c_ready", i), 32'(c_req_ready), 32'(!exp_g[i]));
      chk($sformatf("arb%0d_h_ready", i), 32'(h_req_ready), 32'(exp_g[i]));
      @(posedge clk); @(posedge clk); #2;
      chk($sformatf("arb%0d_c_rsp", i), 32'(c_rsp_valid), 32'(!exp_g[i]));
      chk($sformatf("arb%0d_h_rsp", i), 32'(h_rsp_valid), 32'(exp_g[i]));
      chk($sformatf("arb%0d_rdata", i), exp_g[i] ? h_rsp_rdata : c_rsp_rdata,
          exp_g[i] ? 32'hCAFE_F00D : 32'h1111_1111);
      @(posedge clk); #1;
    end
`ifndef DMEM_ARB_ROUND_ROBIN_EN
    c_req_valid = 1'b0;
    #1;
    chk("arb_fixed_host_ready", 32'(h_req_ready), 32'd1);
    @(posedge clk); @(posedge clk); #2;
    chk("arb_fixed_host_rsp", 32'(h_rsp_valid), 32'd1);
    @(posedge clk); #1;
`endif
    c_req_valid = 1'b0;
    h_req_valid = 1'b0;
    #1;

    // reset during ACCESS of a core read
    c_req_valid = 1'b1; c_req_we = 1'b0; c_req_addr = 32'h4;
    #1;
    chk("rst_mid_ready", 32'(c_req_ready), 32'd1);
    @(posedge clk); #1;
    c_req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid_mem_en", 32'(mem_en), 32'd0);
    @(posedge clk); #2;
    chk("rst_mid_c_rsp", 32'(c_rsp_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_owner", 32'(owner), 32'd0);
    chk("rst_mid_ready0", 32'({c_req_ready, h_req_ready}), 32'd0);
    chk("rst_mid_c_rdata", c_rsp_rdata, 32'h0);
    chk("rst_mid_h_rdata", h_rsp_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    c_req_valid = 1'b1;
    #1;
    chk("rst_mid_rel_ready", 32'(c_req_ready), 32'd0);
    @(posedge clk); #2;
    chk("rst_mid_reopen", 32'(c_req_ready), 32'd1);
    c_req_valid = 1'b0;
    @(posedge clk); #2;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
